// File: rtl/gnr_attractor_ctrl_if.sv
// Request/result bundle between a host and the gene-regulatory-network attractor controller.
interface gnr_attractor_ctrl_if #(
  parameter int N_NODES = 188,
  parameter int CNT_W   = 16
);
  // start is sampled only while busy is low. The result transfers on the cycle in
  // which res_valid and res_ready are both high; until then the master sees
  // res_valid, meet_iter, period, attractor and timeout held constant.
  logic               start;
  logic [N_NODES-1:0] seed;
  logic               busy;
  logic               res_valid;
  logic               res_ready;
  logic [CNT_W-1:0]   meet_iter;
  logic [CNT_W-1:0]   period;
  logic [N_NODES-1:0] attractor;
  logic               timeout;

  modport master (
    output start, seed, res_ready,
    input  busy, res_valid, meet_iter, period, attractor, timeout
  );

  modport slave (
    input  start, seed, res_ready,
    output busy, res_valid, meet_iter, period, attractor, timeout
  );
endinterface

// File: rtl/gnr_attractor_ctrl.sv
// Sequencer for a Boolean gene-regulatory network: Floyd meet detection from a seed,
// then attractor period measurement, result returned over a valid/ready handshake.
module gnr_attractor_ctrl #(
  parameter int               N_NODES  = 188,
  parameter int               CNT_W    = 16,
  parameter logic [CNT_W-1:0] MAX_ITER = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  gnr_attractor_ctrl_if.slave  bus,
  output logic                 reset_nos,
  output logic [N_NODES-1:0]   init_state,
  output logic                 start_s0,
  output logic                 start_s1,
  input  logic [N_NODES-1:0]   s0_vec,
  input  logic [N_NODES-1:0]   s1_vec,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_F_A    = 3'd2,
    S_F_B    = 3'd3,
    S_F_CHK  = 3'd4,
    S_P_STEP = 3'd5,
    S_P_CHK  = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   meet_iter_q;
  logic [CNT_W-1:0]   period_q;
  logic [N_NODES-1:0] attractor_q;
  logic               timeout_q;

  logic [CNT_W-1:0]   meet_inc;
  logic [CNT_W-1:0]   period_inc;
  logic               meet_eq;
  logic               loop_eq;

  // Counters stop at MAX_ITER instead of wrapping.
  assign meet_inc   = (meet_iter_q == MAX_ITER) ? meet_iter_q : meet_iter_q + CNT_W'(1);
  assign period_inc = (period_q == MAX_ITER) ? period_q : period_q + CNT_W'(1);
  assign meet_eq    = (s0_vec == s1_vec);
  assign loop_eq    = (s1_vec == attractor_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      init_state  <= '0;
      meet_iter_q <= '0;
      period_q    <= '0;
      attractor_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            init_state  <= bus.seed;
            meet_iter_q <= '0;
            period_q    <= '0;
            attractor_q <= '0;
            timeout_q   <= 1'b0;
            state       <= S_LOAD;
          end
        end
        S_LOAD: state <= S_F_A;
        S_F_A:  state <= S_F_B;
        S_F_B:  state <= S_F_CHK;
        S_F_CHK: begin
          // Slow copy is k steps in, fast copy 2k steps in.
          meet_iter_q <= meet_inc;
          if (meet_eq) begin
            attractor_q <= s0_vec;
            state       <= S_P_STEP;
          end else if (meet_inc == MAX_ITER) begin
            timeout_q <= 1'b1;
            state     <= S_DONE;
          end else begin
            state <= S_F_A;
          end
        end
        S_P_STEP: state <= S_P_CHK;
        S_P_CHK: begin
          period_q <= period_inc;
          if (loop_eq) begin
            state <= S_DONE;
          end else if (period_inc == MAX_ITER) begin
            timeout_q <= 1'b1;
            state     <= S_DONE;
          end else begin
            state <= S_P_STEP;
          end
        end
        S_DONE: begin
          if (bus.res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Node strobes and status are pure decodes of the registered state.
  assign reset_nos = (state == S_LOAD);
  assign start_s0  = (state == S_F_A) || (state == S_F_B);
  assign start_s1  = (state == S_F_A) || (state == S_F_B) || (state == S_P_STEP);

  assign bus.busy      = (state != S_IDLE);
  assign bus.res_valid = (state == S_DONE);
  assign bus.meet_iter = meet_iter_q;
  assign bus.period    = period_q;
  assign bus.attractor = attractor_q;
  assign bus.timeout   = timeout_q;
  assign dbg_state     = state;

endmodule

// File: doc/gnr_attractor_ctrl.md
Name: gnr_attractor_ctrl

Overview:
- Network-level sequencer and attractor detector for a synthesised gene-regulatory Boolean network.
- Drives the shared control inputs of every node: reset_nos, start_s0, start_s1 and the per-node init_state bit.
- Consumes the concatenated node state vectors s0 (slow copy) and s1 (fast copy).
- Runs Floyd cycle detection from a seed state, then measures the attractor period and returns transient iteration count, period and attractor state over a valid/ready result handshake.

Parameters:
- N_NODES, 188, number of network nodes (width of state vectors).
- CNT_W, 16, width of iteration and period counters.
- MAX_ITER, 16'hFFFF, iteration limit per phase before timeout is declared.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a run; sampled only in IDLE.
- seed  in  N_NODES  initial network state; captured on accepted start.
- busy  out  1  high in every state except IDLE.
- reset_nos  out  1  node load strobe, broadcast to all nodes.
- init_state  out  N_NODES  bit i goes to node i's init_state.
- start_s0  out  1  step strobe, slow copy.
- start_s1  out  1  step strobe, fast copy.
- s0_vec  in  N_NODES  concatenated node s0 outputs.
- s1_vec  in  N_NODES  concatenated node s1 outputs.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when res_valid and res_ready are both high.
- meet_iter  out  CNT_W  Floyd iterations until s0_vec==s1_vec.
- period  out  CNT_W  attractor length in node steps; at least 1.
- attractor  out  N_NODES  s0_vec captured at the meet point.
- timeout  out  1  run aborted by MAX_ITER.

Behaviour:
- Node contract:
  - reset_nos loads both copies and arms the slow copy's pass flag.
  - The slow copy advances on the 1st, 3rd, 5th... start_s0 pulse.
  - The fast copy advances on every start_s1 pulse.
  - s0_vec/s1_vec reflect a pulse in the cycle after that pulse.
- Strobes are decoded combinationally from the registered FSM state. init_state is a register loaded from seed on an accepted start.
- FSM states:
  - IDLE: start=1 → capture seed into init_state; clear counters, timeout and result regs; go to LOAD.
  - LOAD, 1 cycle: reset_nos=1 → go to F_A.
  - F_A: start_s0=start_s1=1 → go to F_B.
  - F_B: start_s0=start_s1=1 → go to F_CHK.
  - F_CHK: no strobes; meet_iter+=1. After the two pulses the slow copy has moved k steps and the fast copy 2k steps.
    - s0_vec==s1_vec: capture attractor=s0_vec; go to P_STEP.
    - Else, if the incremented meet_iter==MAX_ITER: set timeout; go to DONE.
    - Else go to F_A.
  - P_STEP: start_s1=1 only; the slow copy is frozen → go to P_CHK.
  - P_CHK: period+=1.
    - s1_vec==attractor → DONE.
    - Else, if period==MAX_ITER: timeout=1 → DONE.
    - Else → P_STEP.
  - DONE: res_valid=1; all outputs held stable until res_ready=1, then go to IDLE. If res_valid and res_ready are high in the same cycle, IDLE is entered the next cycle and a new start is accepted the cycle after that.
- Timing:
  - Floyd iteration = 3 cycles; period step = 2 cycles.
  - Latency from start to res_valid = 1 + 1 + 3·meet_iter + 2·period + 1 cycles.
- Fixed point: meet_iter=1, period=1.
- On timeout, period, attractor and meet_iter show values reached at abort; period=0 if the abort happens during Floyd.
- start while busy is ignored; seed is not re-sampled.
- Counters saturate at MAX_ITER; no wrap-around.
- rst in any state:
  - Next cycle is IDLE; all strobes 0.
  - res_valid=0, timeout=0, all result outputs and init_state 0.
  - Nodes are left untouched; the next LOAD re-initialises them.
- Equality compare is full N_NODES wide and combinational, registered only through FSM decisions.

Test Plan:
- Fixed point: bench network next(x)=x, seed=any → res_valid after 8 cycles; meet_iter=1, period=1, attractor=seed.
- Pure cycle: N_NODES=4 network next(x)=x+1 mod 16, seed=0 → meet_iter=16, period=16, attractor=0, timeout=0.
- Transient plus cycle (tail 3, loop 5):
  - Table network 0→1→2→3→4→5→6→7→3.
  - Seed=0 → meet_iter=5, period=5, attractor=5.
  - Verify strobe sequence reset_nos, (F_A,F_B,F_CHK)×5, then start_s0 never asserted in P_* states.
- Timeout: MAX_ITER=4, counter network with period 16 → timeout=1 at the 4th F_CHK, period=0.
- Backpressure: hold res_ready=0 for 10 cycles in DONE → res_valid and results stable; start pulses are ignored; the 1-cycle res_ready returns the FSM to IDLE.
- Reset mid-run: assert rst in F_B → next cycle busy=0, res_valid=0, strobes 0; a following start reproduces the scenario 3 result exactly.
